// File: rtl/scroll_background_engine_if.sv
// Pixel-path bus shared by the VGA timing side, the background ROM/palette and the
// scroll engine; widths follow the bitmap geometry.
interface scroll_background_engine_if #(
  parameter int MAP_W = 960,
  parameter int MAP_H = 480,
  parameter int IDX_W = 1
);
  localparam int ADDR_W = $clog2(MAP_W * MAP_H);
  localparam int XOFF_W = $clog2(MAP_W);
  localparam int YOFF_W = $clog2(MAP_H);

  logic              frame_tick;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              collided;
  logic [3:0]        direction;
  logic              home;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic [XOFF_W-1:0] x_off;
  logic [YOFF_W-1:0] y_off;

  modport master (
    output frame_tick, DrawX, DrawY, blank, collided, direction, home,
           rom_q, pal_red, pal_green, pal_blue,
    input  rom_addr, pal_index, red, green, blue, x_off, y_off
  );

  modport slave (
    input  frame_tick, DrawX, DrawY, blank, collided, direction, home,
           rom_q, pal_red, pal_green, pal_blue,
    output rom_addr, pal_index, red, green, blue, x_off, y_off
  );
endinterface

// File: rtl/scroll_background_engine.sv
// Wrapping 2-D scroll offset plus a 4-stage pixel pipeline:
// offset add -> ROM address -> ROM data -> palette-coloured RGB.
module scroll_background_engine #(
  parameter int MAP_W    = 960,
  parameter int MAP_H    = 480,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPEED    = 1,
  parameter int IDX_W    = 1,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0
) (
  input  logic                     vga_clk,
  input  logic                     reset_n,
  scroll_background_engine_if.slave bus
);
  localparam int AW  = $clog2(MAP_W * MAP_H);
  localparam int XW  = $clog2(MAP_W);
  localparam int YW  = $clog2(MAP_H);
  localparam int XS  = XW + 1;
  localparam int YS  = YW + 1;
  localparam int PXW = ((XW > 10) ? XW : 10) + 1;
  localparam int PYW = ((YW > 10) ? YW : 10) + 1;

  localparam logic [XS-1:0] MAP_W_X = XS'(MAP_W);
  localparam logic [YS-1:0] MAP_H_Y = YS'(MAP_H);
  localparam logic [XS-1:0] SPD_X   = XS'(SPEED);
  localparam logic [YS-1:0] SPD_Y   = YS'(SPEED);

  logic [XW-1:0] x_off_q, x_off_d;
  logic [YW-1:0] y_off_q, y_off_d;
  logic          home_pend_q, home_pend_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [2:0]    blank_pipe_q, blank_pipe_d;
  logic [2:0]    coll_pipe_q, coll_pipe_d;
  logic [7:0]    red_q, red_d;
  logic [7:0]    green_q, green_d;
  logic [7:0]    blue_q, blue_d;

  logic [XS-1:0] x_ext, x_plus;
  logic [YS-1:0] y_ext, y_plus;
  logic [XW-1:0] x_inc, x_dec;
  logic [YW-1:0] y_inc, y_dec;
  logic [PXW-1:0] px_sum, px_wrap;
  logic [PYW-1:0] py_sum, py_wrap;

  // Exact modulo stepping: one conditional correction suffices because SPEED < MAP.
  always_comb begin
    x_ext  = {1'b0, x_off_q};
    y_ext  = {1'b0, y_off_q};
    x_plus = x_ext + SPD_X;
    y_plus = y_ext + SPD_Y;
    x_inc  = (x_plus >= MAP_W_X) ? XW'(x_plus - MAP_W_X) : XW'(x_plus);
    y_inc  = (y_plus >= MAP_H_Y) ? YW'(y_plus - MAP_H_Y) : YW'(y_plus);
    x_dec  = (x_ext < SPD_X) ? XW'(x_ext + MAP_W_X - SPD_X) : XW'(x_ext - SPD_X);
    y_dec  = (y_ext < SPD_Y) ? YW'(y_ext + MAP_H_Y - SPD_Y) : YW'(y_ext - SPD_Y);
  end

  always_comb begin
    x_off_d     = x_off_q;
    y_off_d     = y_off_q;
    home_pend_d = home_pend_q | bus.home;
    if (bus.frame_tick) begin
      home_pend_d = 1'b0;
      if (home_pend_q || bus.home) begin
        x_off_d = XW'(INIT_X);
        y_off_d = YW'(INIT_Y);
      end else if (!bus.collided) begin
        case (bus.direction[1:0])
          2'b10:   x_off_d = x_inc;
          2'b01:   x_off_d = x_dec;
          default: x_off_d = x_off_q;
        endcase
        case (bus.direction[3:2])
          2'b10:   y_off_d = y_dec;
          2'b01:   y_off_d = y_inc;
          default: y_off_d = y_off_q;
        endcase
      end
    end
  end

  // Off-screen coordinates map to column/row 0 so the ROM address always stays in range.
  always_comb begin
    px_sum  = PXW'(bus.DrawX) + PXW'(x_off_q);
    py_sum  = PYW'(bus.DrawY) + PYW'(y_off_q);
    px_wrap = (px_sum >= PXW'(MAP_W)) ? px_sum - PXW'(MAP_W) : px_sum;
    py_wrap = (py_sum >= PYW'(MAP_H)) ? py_sum - PYW'(MAP_H) : py_sum;
    px_d    = (PXW'(bus.DrawX) >= PXW'(SCREEN_W)) ? '0 : XW'(px_wrap);
    py_d    = (PYW'(bus.DrawY) >= PYW'(SCREEN_H)) ? '0 : YW'(py_wrap);
  end

  always_comb begin
    rom_addr_d   = AW'(py_q) * AW'(MAP_W) + AW'(px_q);
    blank_pipe_d = {blank_pipe_q[1:0], bus.blank};
    coll_pipe_d  = {coll_pipe_q[1:0], bus.collided};
    red_d        = 8'h00;
    green_d      = 8'h00;
    blue_d       = 8'h00;
    if (blank_pipe_q[2] && !coll_pipe_q[2]) begin
      red_d   = {bus.pal_red, bus.pal_red};
      green_d = {bus.pal_green, bus.pal_green};
      blue_d  = {bus.pal_blue, bus.pal_blue};
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_off_q      <= XW'(INIT_X);
      y_off_q      <= YW'(INIT_Y);
      home_pend_q  <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      rom_addr_q   <= '0;
      blank_pipe_q <= '0;
      coll_pipe_q  <= '0;
      red_q        <= 8'h00;
      green_q      <= 8'h00;
      blue_q       <= 8'h00;
    end else begin
      x_off_q      <= x_off_d;
      y_off_q      <= y_off_d;
      home_pend_q  <= home_pend_d;
      px_q         <= px_d;
      py_q         <= py_d;
      rom_addr_q   <= rom_addr_d;
      blank_pipe_q <= blank_pipe_d;
      coll_pipe_q  <= coll_pipe_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pal_index = bus.rom_q;
  assign bus.red       = red_q;
  assign bus.green     = green_q;
  assign bus.blue      = blue_q;
  assign bus.x_off     = x_off_q;
  assign bus.y_off     = y_off_q;
endmodule

// File: doc/scroll_background_engine.md
# scroll_background_engine

Parametrised scrolling-background renderer for the Bosconian display path. It keeps a wrapping 2-D scroll offset into a background bitmap of MAP_W x MAP_H pixels, updates that offset once per frame from the player direction (diagonals allowed), and computes the external ROM address for each DrawX/DrawY. It then maps the returned palette index through an external palette and drives registered 8-bit RGB through a fixed-latency pipeline. It sits between the VGA timing controller and the colour mapper.

## Interface
Parameters:
- MAP_W, 960: bitmap width in pixels; must be >= SCREEN_W
- MAP_H, 480: bitmap height in pixels; must be >= SCREEN_H
- SCREEN_W, 640: visible width
- SCREEN_H, 480: visible height
- SPEED, 1: pixels moved per frame per axis; 1 <= SPEED < min(MAP_W, MAP_H)
- IDX_W, 1: palette index width
- INIT_X, 0 / INIT_Y, 0: offset loaded at reset and on home

Ports:
- vga_clk  in  1  pixel clock, the only clock
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse, once per frame, during vertical blank
- DrawX, DrawY  in  10 each  current pixel coordinate
- blank  in  1  1 = active video
- collided  in  1  1 = player hit; freeze scroll, black output
- direction  in  4  {up, down, right, left}
- home  in  1  pulse: reload INIT_X/INIT_Y at the next frame_tick
- rom_addr  out  clog2(MAP_W*MAP_H)  registered ROM address
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr
- pal_index  out  IDX_W  equals rom_q (combinational)
- pal_red, pal_green, pal_blue  in  4 each  palette colour, combinational from pal_index
- red, green, blue  out  8 each  registered pixel colour
- x_off, y_off  out  clog2(MAP_W), clog2(MAP_H)  current scroll offset, for sprite alignment

## Operation
- Offset state x_off in [0, MAP_W-1] and y_off in [0, MAP_H-1]. Offsets change only on cycles where frame_tick=1. All other cycles hold them.
- On frame_tick, the following rules apply in priority order:
  - If home is pending, load INIT_X/INIT_Y and clear the pending flag. A home pulse latches into the pending flag on any cycle.
  - Else if collided=1, hold the offsets.
  - Else apply direction per axis:
    - up only: y_off -= SPEED. down only: y_off += SPEED.
    - right only: x_off += SPEED. left only: x_off -= SPEED.
    - up+down together: y holds. right+left together: x holds.
    - One bit from each axis gives a diagonal move.
    - direction = 0: hold. Offsets are never reset by an idle direction.
- Wrap arithmetic is exact modulo. The add rule is: if off+SPEED >= MAP, the result is off+SPEED-MAP. The subtract rule is: if off < SPEED, the result is off+MAP-SPEED. There is no truncation to 2^n.
- Pixel coordinates:
  - px = DrawX + x_off, minus MAP_W if the sum is >= MAP_W. py is computed the same way with DrawY, y_off and MAP_H.
  - A single conditional subtract is sufficient given the parameter constraints.
  - Intermediate sums are one bit wider than the operands.
  - DrawX >= SCREEN_W or DrawY >= SCREEN_H is don't-care, but must not produce X.
- rom_addr = py*MAP_W + px, computed at full width and always < MAP_W*MAP_H.
- Colour: when the delayed blank=1 and the delayed collided=0, output is {pal_red,pal_red}, {pal_green,pal_green}, {pal_blue,pal_blue} (nibble replicated, so 4'hF gives 8'hFF). Otherwise output is 0.
- Reset (async assert, sync release): x_off=INIT_X, y_off=INIT_Y, home pending cleared, rom_addr=0, red/green/blue=0, all pipeline valids/blank delays cleared.

## Timing
- Pipeline stages:
  - Cycle c: DrawX/DrawY/blank/collided presented.
  - c+1: px/py registered.
  - c+2: rom_addr registered.
  - c+3: rom_q valid.
  - c+4: red/green/blue valid.
- Fixed latency is 4 cycles. blank and collided are delayed 3 registers so they align with rom_q for the final register.
- Each pixel uses the offset sampled when it entered stage 1. An offset update on frame_tick affects pixels presented from the cycle after the tick onward.
- Throughput is one pixel per vga_clk, with no stalls and no backpressure.
- Reset mid-line: outputs are 0 immediately on assertion. The first valid RGB appears 4 cycles after the first post-release pixel.

## Test plan
- Reset, then DrawX=5, DrawY=2, blank=1, INIT=0, MAP_W=960 -> rom_addr=1925 at c+2; RGB=replicated palette of rom_q at c+4; all outputs 0 during reset.
- direction=0010, 10 frame_ticks with SPEED=1 -> x_off=10; then direction=0000 for 5 ticks -> x_off stays 10; DrawX=0, DrawY=0 -> rom_addr=10.
- Left wrap: x_off=0, direction=0001, SPEED=3 -> x_off=957. Right wrap: x_off=959, direction=0010, SPEED=1 -> x_off=0. DrawX=639 with x_off=500 -> px=179.
- Diagonal plus cancel: direction=1010 from (0,0) -> (1,479); direction=1100 -> y unchanged.
- collided=1 with direction=0100 for 3 ticks -> offsets frozen; RGB=0 exactly from 4 cycles after collided rises; home pulse mid-frame then tick -> offsets=INIT.
- blank toggled every cycle -> RGB zero and non-zero pattern identical to blank shifted by 4 cycles.
